// File: rtl/sseg_word_display.sv
// sseg_word_display: pops 32-bit words from a FWFT buffer and shows each as 8 hex digits
// on a multiplexed common-anode display for a fixed hold time.
module sseg_word_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        write_ready,
  input  logic [31:0] writeback,
  output logic        read_en,
  output logic [7:0]  SSEG_AN,
  output logic [7:0]  SSEG_CA,
  output logic        busy
);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int RW = $clog2(REFRESH_DIV);
  // full cathode bytes for hex 0..F, digit 0 in the low byte
  localparam logic [127:0] HEX = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
                                  8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  typedef enum logic {IDLE, HOLD} state_t;
  state_t          state, state_nx;
  logic [HW-1:0]   hold_cnt, hold_nx;
  logic [RW-1:0]   refresh_cnt;
  logic [2:0]      digit_idx;
  logic [31:0]     disp_word;
  logic            shown;
  logic [3:0]      nib;
  logic            refresh_wrap;
  always_comb begin
    read_en  = n_rst & write_ready & (state == IDLE | (state == HOLD & hold_cnt == '0));
    state_nx = read_en ? HOLD : (state == HOLD && hold_cnt == '0) ? IDLE : state;
    hold_nx  = read_en ? HW'(HOLD_CYCLES - 1) : (state == HOLD && hold_cnt != '0) ? hold_cnt - 1'b1 : hold_cnt;
    nib          = disp_word[{digit_idx, 2'b00} +: 4];
    refresh_wrap = refresh_cnt == RW'(REFRESH_DIV - 1);
  end
  assign busy = state == HOLD;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      disp_word   <= '0;
      shown       <= 1'b0;
      refresh_cnt <= '0;
      digit_idx   <= '0;
      SSEG_AN     <= 8'hFF;
      SSEG_CA     <= 8'hFF;
    end else begin
      state       <= state_nx;
      hold_cnt    <= hold_nx;
      disp_word   <= read_en ? writeback : disp_word;
      shown       <= shown | read_en;
      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
      digit_idx   <= refresh_wrap ? digit_idx + 1'b1 : digit_idx;
      SSEG_AN     <= shown ? ~(8'b1 << digit_idx) : 8'hFF;
      SSEG_CA     <= shown ? HEX[{nib, 3'b000} +: 8] : 8'hFF;
    end
  end
endmodule

// File: tb/tb_sseg_word_display.sv
// tb_sseg_word_display: randomized FWFT-buffer stimulus checked against a timing/arithmetic model.
module tb_sseg_word_display;
  localparam int R = 4;
  localparam int H = 10;
  logic        clk = 0;
  logic        n_rst = 0;
  logic        write_ready = 0;
  logic [31:0] writeback = 0;
  logic        read_en, busy;
  logic [7:0]  SSEG_AN, SSEG_CA;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  bit          popped;
  int          since, edges;
  logic [31:0] mword;
  logic [7:0]  seg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  always #5 clk = ~clk;
  sseg_word_display #(.REFRESH_DIV(R), .HOLD_CYCLES(H)) dut (
    .clk(clk), .n_rst(n_rst), .write_ready(write_ready), .writeback(writeback),
    .read_en(read_en), .SSEG_AN(SSEG_AN), .SSEG_CA(SSEG_CA), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    popped = 0;
    since  = 0;
    edges  = 0;
    mword  = 0;
  endtask
  // one clock cycle: entered and left 1 time unit after a rising edge
  task automatic cyc();
    bit         pop;
    int         d;
    logic [7:0] ea, ec;
    write_ready = q.size() > 0;
    writeback   = write_ready ? q[0] : $urandom;
    pop = write_ready && (!popped || since >= H);
    #3;
    check("read_en", read_en, pop);
    check("busy", busy, popped && since <= H);
    d  = (edges / R) % 8;
    ea = popped ? ~(8'b1 << d) : 8'hFF;
    ec = popped ? seg[mword[4*d +: 4]] : 8'hFF;
    @(posedge clk);
    if (pop) begin
      mword  = q.pop_front();
      popped = 1;
      since  = 1;
    end else since++;
    edges++;
    #1;
    check("an", SSEG_AN, ea);
    check("ca", SSEG_CA, ec);
  endtask
  task automatic run(input int n);
    repeat (n) cyc();
  endtask
  task automatic do_reset();
    n_rst       = 0;
    write_ready = 1;
    writeback   = $urandom;
    #1;
    check("rst_read_en", read_en, 0);
    check("rst_an", SSEG_AN, 8'hFF);
    check("rst_ca", SSEG_CA, 8'hFF);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_an", SSEG_AN, 8'hFF);
    check("rst_hold_read_en", read_en, 0);
    n_rst = 1;
    model_reset();
  endtask
  initial begin
    int n;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    q.push_back(32'h0123ABCD);
    run(40);
    q.push_back(32'h11111111);
    q.push_back(32'h22222222);
    q.push_back(32'h33333333);
    run(45);
    q.push_back(32'h89ABCDEF);
    run(40);
    q.push_back(32'h01234567);
    run(40);
    repeat (400) begin
      if ($urandom_range(7) == 0) q.push_back($urandom);
      cyc();
    end
    q.delete();
    run(15);
    q.push_back($urandom);
    n = 0;
    while (!(popped && since == 5) && n < 40) begin
      cyc();
      n++;
    end
    check("reach_mid_hold", n < 40, 1);
    do_reset();
    q.push_back($urandom);
    q.push_back($urandom);
    run(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sseg_word_display.md
# sseg_word_display

Downstream consumer of the writeback data buffer in the FPGA top level. When the buffer is non-empty, it pops one 32-bit writeback word and latches it. It then shows the word as 8 hex digits on the board's multiplexed common-anode seven-segment display for a fixed hold time before taking the next word. It runs on the fast board clock, the same domain as the buffer, so the core's results are paced to human-readable speed.

## Interface
- REFRESH_DIV, 100000: clk cycles each digit is lit before the scan advances; must be ≥ 2.
- HOLD_CYCLES, 100000000: clk cycles a latched word is held before the next pop; must be ≥ 2.
- clk  input  1  board clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- write_ready  input  1  buffer non-empty; writeback holds the head word (first-word-fall-through).
- writeback  input  32  head word of the buffer, valid while write_ready = 1.
- read_en  output  1  pop strobe to the buffer; one cycle per word consumed.
- SSEG_AN  output  8  anode enables, active low; bit i = digit i; digit 0 is the rightmost.
- SSEG_CA  output  8  cathodes, active low, ordered {DP,g,f,e,d,c,b,a}.
- busy  output  1  high while in HOLD.

## Operation
- Registers: state (IDLE/HOLD), disp_word[31:0], shown (a word has ever been latched), hold_cnt, refresh_cnt, digit_idx[2:0], SSEG_AN, SSEG_CA.
- Reset values: state IDLE, disp_word 0, shown 0, hold_cnt 0, refresh_cnt 0, digit_idx 0, SSEG_AN 8'hFF, SSEG_CA 8'hFF, busy 0.
- read_en = n_rst & write_ready & (state==IDLE | (state==HOLD & hold_cnt==0)). It is combinational and gated by n_rst, so it is 0 throughout reset.
- On any edge where read_en = 1:
  - disp_word ← writeback, shown ← 1, hold_cnt ← HOLD_CYCLES−1, state ← HOLD.
- IDLE with write_ready = 0: stay in IDLE; keep displaying the last word.
- HOLD with hold_cnt ≠ 0: decrement hold_cnt.
- HOLD with hold_cnt = 0 and write_ready = 0: go to IDLE.
- The word stays displayed after the hold expires until a new word is popped.
- Scan, free-running from reset regardless of state:
  - refresh_cnt counts 0..REFRESH_DIV−1, then wraps to 0.
  - On the wrap edge, digit_idx increments and wraps from 7 to 0.
- Output registers, updated every edge:
  - SSEG_AN ← shown ? ~(8'b1 << digit_idx) : 8'hFF.
  - SSEG_CA ← shown ? {1'b1, seg(disp_word[4·digit_idx+3 : 4·digit_idx])} : 8'hFF.
- Hex decode (full SSEG_CA byte, DP off), digits 0–F: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E.
- No leading-zero blanking; all 8 digits are lit once shown = 1.

## Timing
- Pop latency: read_en rises in the same cycle as write_ready when in IDLE. The buffer and disp_word both update on that edge.
- Back-to-back words: pops occur exactly HOLD_CYCLES cycles apart when the buffer stays non-empty.
- Display latency: SSEG_AN/SSEG_CA reflect a new disp_word or digit_idx one edge later (registered outputs).
- First pop after reset: SSEG_AN leaves 8'hFF one edge after the pop edge.
- Each digit is lit for exactly REFRESH_DIV cycles. A full 8-digit frame is 8·REFRESH_DIV cycles.
- A word change mid-frame takes effect on the next output update without resetting the scan position.
- Reset asserted mid-hold: all registers return to reset values immediately and read_en drops to 0. The display blanks until the next pop after release.
- write_ready dropping during HOLD has no effect. Writeback is sampled only on pop edges.

## Test plan
- Reset: with n_rst = 0 and write_ready = 1, check read_en = 0, SSEG_AN = FF, SSEG_CA = FF. After release, read_en = 1 in the first cycle.
- Single word, REFRESH_DIV = 4: push 32'h0123ABCD. Expect one read_en pulse, then digit 0 (AN = FE) shows CA = A1 (d) for 4 cycles, then digit 1 (AN = FD) shows C6 (C). Digit 7 (AN = 7F) shows C0.
- Hold pacing, HOLD_CYCLES = 10: preload 3 words. Expect read_en pulses at cycles t, t+10, t+20, each exactly 1 cycle wide, and no 4th pulse.
- Empty after hold: with one word and HOLD_CYCLES = 10, expect state IDLE and busy = 0 at t+10. The word stays displayed; a new push at t+25 pops in the same cycle.
- Decode sweep: word 32'h89ABCDEF, then 32'h01234567. Verify all 16 CA codes across the scan.
- Mid-hold reset: assert n_rst at hold_cnt = 5. Expect immediate blank (AN = FF), read_en = 0, and digit_idx restarting at 0 after release.
